uart_hex_line_rx: RTL and testbench
===================================

# uart_hex_line_rx

Synthesizable UART receiver that decodes newline-terminated ASCII hexadecimal lines into binary words, with a valid/ready output handshake and sticky error flags. It replaces the bench-only hex-line decoder and sits behind the user-area UART pin, feeding decoded command/data words to the Wishbone-side register logic. It is generalised in baud divisor, result width, case handling and error reporting, with optional parity.

## Interface
- CLKS_PER_BIT, 1042, wb_clk_i cycles per UART bit (10 MHz / 9600 baud); legal range is ≥ 4.
- DATA_W, 32, result width; must be a multiple of 4; MAX_DIGITS = DATA_W/4.
- wb_clk_i  in  1  single clock; all logic is on its rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- rx_i  in  1  asynchronous serial input; idles high.
- value_o  out  DATA_W  decoded value, right-aligned; stable while valid_o=1.
- digits_o  out  $clog2(MAX_DIGITS+1)  count of hex digits in the line.
- valid_o  out  1  a decoded word is available.
- ready_i  in  1  consumer accepts the word when valid_o & ready_i.
- err_frame_o  out  1  sticky: stop bit was sampled low.
- err_char_o  out  1  sticky: a non-hex, non-CR/LF character was received.
- err_ovf_o  out  1  sticky: the line had more than MAX_DIGITS significant digits.
- err_ovr_o  out  1  sticky: a line completed while valid_o was still high.
- err_parity_o  out  1  sticky: parity mismatch; tied 0 without the macro.
- clr_err_i  in  1  one-cycle pulse that clears all sticky error flags.

## Operation
- rx_i passes through a 2-FF synchronizer. Both flops reset to 1.
- Byte FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE→START on a synchronized low.
  - START: at CLKS_PER_BIT/2 the line is resampled. Low → DATA. High → IDLE (glitch, no error).
  - DATA: 8 samples are taken, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sampled at mid-bit, then the FSM returns to IDLE immediately so it can catch a back-to-back start bit.
- Character handling:
  - '0'-'9', 'A'-'F' and 'a'-'f': acc ← {acc[DATA_W-5:0], nibble}. digits increments and saturates at MAX_DIGITS.
  - If acc[DATA_W-1:DATA_W-4] ≠ 0 before a shift: set err_ovf_o and mark the line bad. Leading zeros never overflow.
  - '\r' (0x0D) is ignored.
  - Any other character: set err_char_o and mark the line bad.
  - A frame error (stop bit low) discards the byte, sets err_frame_o and marks the line bad.
- On '\n' (0x0A):
  - If the line is good and digits > 0 and valid_o=0: load value_o and digits_o, then set valid_o.
  - If the line is good and digits > 0 and valid_o=1: drop the new word, set err_ovr_o, and leave the held word unchanged.
  - If the line is bad or empty: no output.
  - In all cases acc, digits and the bad flag clear.
- valid_o clears on the cycle after valid_o & ready_i.
- If a set and clr_err_i occur in the same cycle, the set wins.

## Timing
- Reset values:
  - valid_o, value_o, digits_o and all err_* outputs are 0.
  - FSM in IDLE; acc, digits and the line-bad flag are 0.
- Reset mid-frame aborts the byte and the line; no partial output.
- Input latency: 2 cycles for the synchronizer.
- Output latency: valid_o rises 1 cycle after the mid-stop-bit sample of the '\n' byte.
- The stop sample falls at about 9.5·CLKS_PER_BIT cycles after the start edge (10.5 with parity).
- ready_i may be held high permanently. The handshake then completes in 1 cycle and the word is visible for exactly 1 cycle.
- Throughput: one byte per 10 (11) bit times. A handshake never stalls the receiver.

## Configuration
- UART_HEX_PARITY_EN defined:
  - An even-parity bit is expected between the data bits and the stop bit (PARITY state).
  - Mismatch sets err_parity_o, discards the byte and marks the line bad.
- UART_HEX_PARITY_EN undefined:
  - There is no PARITY state; the frame is 8N1.
  - err_parity_o is constant 0.

## Structure
- Package uart_hex_pkg holds:
  - the byte-FSM state enum;
  - ASCII constants: ASCII_LF=8'h0A, ASCII_CR=8'h0D;
  - function hex_nibble(byte) returning {is_hex, nibble[3:0]}.
- Sub-module uart_rx_byte holds the synchronizer, bit FSM and baud counter. Its outputs are byte_o[7:0], a one-cycle byte_vld_o pulse, frame_err_o and parity_err_o.
- The top level holds the line accumulator, error flags and the output handshake.

## Test plan
All scenarios use CLKS_PER_BIT=16 and DATA_W=32.
- Send "1A2b\n" with ready_i=1 → valid_o for 1 cycle, value_o=32'h00001A2B, digits_o=4, no errors.
- Send "00000000FF\n" → value_o=32'h000000FF, no err_ovf_o. Send "123456789\n" → err_ovf_o=1, no valid_o.
- Send "12G4\n", then "\r\n", then "7\n" → err_char_o=1. First two lines give no output. Third gives value_o=7.
- With ready_i=0, send "5\n" then "6\n" → value_o stays 5, err_ovr_o=1. Then pulse ready_i → valid_o drops the next cycle.
- Send a byte with its stop bit low, then "\n" → err_frame_o=1, no valid_o. Pulse clr_err_i → all errors read 0.
- Assert wb_rst_i mid-byte while sending "AB\n", then send "C\n" → value_o=32'hC only. With UART_HEX_PARITY_EN, a bad parity bit → err_parity_o=1.

Source files
------------

// File: rtl/uart_hex_pkg.sv
// Shared types and helpers for the hex-line UART receiver.
// Defining UART_HEX_PARITY_EN adds the PARITY state to the byte FSM.
package uart_hex_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_HEX_PARITY_EN
        StParity,
`endif
        StStop
    } rx_state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Returns {is_hex, nibble}; nibble reads 0 for non-hex characters.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: input synchronizer, baud counter and bit FSM (8N1, or 8E1 when
// UART_HEX_PARITY_EN is defined). Status outputs pulse on the mid-stop-bit sample cycle.
module uart_rx_byte
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1, r_sync2;
    rx_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [2:0]       r_bit, w_bit_d;
    logic [7:0]       r_shift, w_shift_d;
    logic             w_tick, w_half;
`ifdef UART_HEX_PARITY_EN
    logic             r_par_bad, w_par_bad_d;
`endif

    assign w_tick = (r_cnt == FULL_M1);
    assign w_half = (r_cnt == HALF_M1);
    assign byte_o = r_shift;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt + CNT_W'(1);
        w_bit_d      = r_bit;
        w_shift_d    = r_shift;
        byte_vld_o   = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
`ifdef UART_HEX_PARITY_EN
        w_par_bad_d  = r_par_bad;
`endif
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!r_sync2) w_state_d = StStart;
            end
            StStart: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (w_half) begin
                    w_cnt_d   = '0;
                    w_bit_d   = 3'd0;
                    w_state_d = r_sync2 ? StIdle : StData;
                end
            end
            StData: begin
                if (w_tick) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef UART_HEX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end else begin
                        w_bit_d = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_HEX_PARITY_EN
            StParity: begin
                if (w_tick) begin
                    w_cnt_d     = '0;
                    w_par_bad_d = ^{r_shift, r_sync2};
                    w_state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (w_tick) begin
                    w_cnt_d     = '0;
                    w_state_d   = StIdle;
                    frame_err_o = !r_sync2;
`ifdef UART_HEX_PARITY_EN
                    parity_err_o = r_par_bad;
                    byte_vld_o   = r_sync2 && !r_par_bad;
`else
                    byte_vld_o   = r_sync2;
`endif
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
`ifdef UART_HEX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_bit     <= w_bit_d;
            r_shift   <= w_shift_d;
`ifdef UART_HEX_PARITY_EN
            r_par_bad <= w_par_bad_d;
`endif
        end
    end

endmodule

// File: rtl/uart_hex_line_rx.sv
// Decodes newline-terminated ASCII hex lines from a UART into words with a valid/ready
// handshake and sticky error flags. UART_HEX_PARITY_EN enables even-parity checking.
module uart_hex_line_rx
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter int unsigned DATA_W       = 32,
    localparam int unsigned MAX_DIGITS  = DATA_W / 4,
    localparam int unsigned DIG_W       = $clog2(MAX_DIGITS + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] value_o,
    output logic [DIG_W-1:0]  digits_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              err_frame_o,
    output logic              err_char_o,
    output logic              err_ovf_o,
    output logic              err_ovr_o,
    output logic              err_parity_o,
    input  logic              clr_err_i
);

    logic [7:0]        w_byte;
    logic              w_byte_vld, w_frame_err, w_par_err;
    logic [4:0]        w_nib;
    logic [DATA_W-1:0] r_acc, w_acc_d, r_value, w_value_d;
    logic [DIG_W-1:0]  r_digits, w_digits_d, r_dout, w_dout_d;
    logic              r_bad, w_bad_d, r_valid, w_valid_d;
    logic              w_set_char, w_set_ovf, w_set_ovr;
    logic              r_err_frame, r_err_char, r_err_ovf, r_err_ovr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .rx_i        (rx_i),
        .byte_o      (w_byte),
        .byte_vld_o  (w_byte_vld),
        .frame_err_o (w_frame_err),
        .parity_err_o(w_par_err)
    );

    assign w_nib = hex_nibble(w_byte);

    always_comb begin
        w_acc_d    = r_acc;
        w_digits_d = r_digits;
        w_bad_d    = r_bad;
        w_valid_d  = r_valid;
        w_value_d  = r_value;
        w_dout_d   = r_dout;
        w_set_char = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_ovr  = 1'b0;
        if (r_valid && ready_i) w_valid_d = 1'b0;
        if (w_frame_err || w_par_err) begin
            w_bad_d = 1'b1;
        end else if (w_byte_vld) begin
            if (w_nib[4]) begin
                // A nonzero top nibble means this shift would drop a significant digit.
                if (r_acc[DATA_W-1 -: 4] != 4'd0) begin
                    w_set_ovf = 1'b1;
                    w_bad_d   = 1'b1;
                end
                w_acc_d = {r_acc[DATA_W-5:0], w_nib[3:0]};
                if (r_digits != DIG_W'(MAX_DIGITS)) w_digits_d = r_digits + DIG_W'(1);
            end else if (w_byte == ASCII_LF) begin
                if (!r_bad && r_digits != '0) begin
                    if (r_valid) begin
                        w_set_ovr = 1'b1;
                    end else begin
                        w_valid_d = 1'b1;
                        w_value_d = r_acc;
                        w_dout_d  = r_digits;
                    end
                end
                w_acc_d    = '0;
                w_digits_d = '0;
                w_bad_d    = 1'b0;
            end else if (w_byte != ASCII_CR) begin
                w_set_char = 1'b1;
                w_bad_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_acc       <= '0;
            r_digits    <= '0;
            r_bad       <= 1'b0;
            r_valid     <= 1'b0;
            r_value     <= '0;
            r_dout      <= '0;
            r_err_frame <= 1'b0;
            r_err_char  <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_acc       <= w_acc_d;
            r_digits    <= w_digits_d;
            r_bad       <= w_bad_d;
            r_valid     <= w_valid_d;
            r_value     <= w_value_d;
            r_dout      <= w_dout_d;
            // A new error in the same cycle as a clear survives the clear.
            r_err_frame <= (r_err_frame && !clr_err_i) || w_frame_err;
            r_err_char  <= (r_err_char && !clr_err_i) || w_set_char;
            r_err_ovf   <= (r_err_ovf && !clr_err_i) || w_set_ovf;
            r_err_ovr   <= (r_err_ovr && !clr_err_i) || w_set_ovr;
        end
    end

`ifdef UART_HEX_PARITY_EN
    logic r_err_par;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_err_par <= 1'b0;
        else          r_err_par <= (r_err_par && !clr_err_i) || w_par_err;
    end

    assign err_parity_o = r_err_par;
`else
    assign err_parity_o = 1'b0;
`endif

    assign value_o     = r_value;
    assign digits_o    = r_dout;
    assign valid_o     = r_valid;
    assign err_frame_o = r_err_frame;
    assign err_char_o  = r_err_char;
    assign err_ovf_o   = r_err_ovf;
    assign err_ovr_o   = r_err_ovr;

endmodule

// File: tb/tb_uart_hex_line_rx.sv
// Self-checking bench for uart_hex_line_rx: serial stimulus against a line-level model.
module tb_uart_hex_line_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXD = DW / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          ready = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] value;
    logic [3:0]    digits;
    logic          valid;
    logic          d_frame, d_char, d_ovf, d_ovr, d_par;

    uart_hex_line_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .value_o     (value),
        .digits_o    (digits),
        .valid_o     (valid),
        .ready_i     (ready),
        .err_frame_o (d_frame),
        .err_char_o  (d_char),
        .err_ovf_o   (d_ovf),
        .err_ovr_o   (d_ovr),
        .err_parity_o(d_par),
        .clr_err_i   (clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Words seen crossing the handshake, and the words the model expects.
    logic [DW-1:0] got_val[$];
    int            got_dig[$];
    logic [DW-1:0] exp_val[$];
    int            exp_dig[$];
    int            vcyc;

    // Line-level model state.
    int            m_nibs[$];
    bit            m_bad, m_held;
    logic [DW-1:0] m_held_val;
    int            m_held_dig;
    bit            x_frame, x_char, x_ovf, x_ovr, x_par;

    always @(negedge clk) begin
        if (!rst && valid) begin
            vcyc++;
            if (ready) begin
                got_val.push_back(value);
                got_dig.push_back(int'(digits));
            end
        end
    end

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_reset();
        m_nibs.delete();
        m_bad = 0; m_held = 0;
        x_frame = 0; x_char = 0; x_ovf = 0; x_ovr = 0; x_par = 0;
    endtask

    task automatic model_eol();
        int            sig = 0;
        int            dig;
        logic [DW-1:0] val = '0;
        foreach (m_nibs[i]) begin
            if (sig > 0 || m_nibs[i] != 0) sig++;
            val = val * 16 + DW'(m_nibs[i]);
        end
        if (sig > MAXD) begin x_ovf = 1; m_bad = 1; end
        dig = (m_nibs.size() > MAXD) ? MAXD : m_nibs.size();
        if (!m_bad && m_nibs.size() > 0) begin
            if (m_held) x_ovr = 1;
            else if (ready) begin exp_val.push_back(val); exp_dig.push_back(dig); end
            else begin m_held = 1; m_held_val = val; m_held_dig = dig; end
        end
        m_nibs.delete();
        m_bad = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) model_eol();
        else if (c == 8'h0D) begin end
        else if (hexval(c) >= 0) m_nibs.push_back(hexval(c));
        else begin m_bad = 1; x_char = 1; end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_HEX_PARITY_EN
        bit_time((^b) ^ bad_par);
`endif
        if (bad_stop) begin
            rx = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            bit_time(1'b1);
        end else begin
            bit_time(1'b1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b0, 1'b0);
            model_char(s[i]);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        got_val.delete(); got_dig.delete();
        exp_val.delete(); exp_dig.delete();
        vcyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (value !== '0) begin n_fail++; $display("FAIL reset_value: got %h want 0", value); end
        n_checks++;
        if (digits !== 4'd0) begin n_fail++; $display("FAIL reset_digits: got %0d want 0", digits); end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_errs: got %b want 00000", {d_frame, d_char, d_ovf, d_ovr, d_par});
        end
        rst = 1'b0;
        model_reset();
        clear_queues();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_queues();
        ready = 1'b1;
        send_str("1A2b\n");
        n_checks++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            n_checks++;
            if (got_val[0] !== exp_val[0] || got_val[0] !== 32'h00001A2B || got_dig[0] != 4) begin
                n_fail++;
                $display("FAIL basic_word: got %h/%0d want 00001a2b/4", got_val[0], got_dig[0]);
            end
        end
        n_checks++;
        if (vcyc != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc); end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== 5'b0) begin
            n_fail++;
            $display("FAIL basic_errs: got %b want 00000", {d_frame, d_char, d_ovf, d_ovr, d_par});
        end
    endtask

    task automatic test_ovf();
        clear_queues();
        send_str("00000000FF\n");
        n_checks++;
        if (d_ovf !== 1'b0) begin n_fail++; $display("FAIL lead_zero_ovf: got %b want 0", d_ovf); end
        send_str("123456789\n");
        n_checks++;
        if (got_val.size() != exp_val.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            foreach (exp_val[i]) begin
                n_checks++;
                if (got_val[i] !== exp_val[i] || got_dig[i] != exp_dig[i]) begin
                    n_fail++;
                    $display("FAIL ovf_word%0d: got %h/%0d want %h/%0d",
                             i, got_val[i], got_dig[i], exp_val[i], exp_dig[i]);
                end
            end
        end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== {x_frame, x_char, x_ovf, x_ovr, x_par}) begin
            n_fail++;
            $display("FAIL ovf_errs: got %b want %b", {d_frame, d_char, d_ovf, d_ovr, d_par},
                     {x_frame, x_char, x_ovf, x_ovr, x_par});
        end
    endtask

    task automatic test_char_err();
        clear_queues();
        send_str("12G4\n");
        send_str("\015\n");
        send_str("7\n");
        n_checks++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            n_fail++;
            $display("FAIL char_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            n_checks++;
            if (got_val[0] !== exp_val[0] || got_dig[0] != exp_dig[0]) begin
                n_fail++;
                $display("FAIL char_word: got %h/%0d want %h/%0d",
                         got_val[0], got_dig[0], exp_val[0], exp_dig[0]);
            end
        end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== {x_frame, x_char, x_ovf, x_ovr, x_par}) begin
            n_fail++;
            $display("FAIL char_errs: got %b want %b", {d_frame, d_char, d_ovf, d_ovr, d_par},
                     {x_frame, x_char, x_ovf, x_ovr, x_par});
        end
    endtask

    task automatic test_overrun();
        clear_queues();
        ready = 1'b0;
        send_str("5\n");
        send_str("6\n");
        n_checks++;
        if (valid !== 1'b1 || value !== m_held_val || int'(digits) != m_held_dig) begin
            n_fail++;
            $display("FAIL ovr_held: got v=%b %h/%0d want v=1 %h/%0d",
                     valid, value, digits, m_held_val, m_held_dig);
        end
        n_checks++;
        if (d_ovr !== x_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", d_ovr, x_ovr); end
        ready = 1'b1;
        if (m_held) begin exp_val.push_back(m_held_val); exp_dig.push_back(m_held_dig); m_held = 0; end
        @(posedge clk);
        #1;
        ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b want 0", valid); end
        n_checks++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            n_checks++;
            if (got_val[0] !== exp_val[0]) begin
                n_fail++;
                $display("FAIL ovr_word: got %h want %h", got_val[0], exp_val[0]);
            end
        end
        @(posedge clk);
        #1;
        ready = 1'b1;
    endtask

    task automatic test_frame_err_clr();
        clear_queues();
        send_byte("A", 1'b1, 1'b0);
        x_frame = 1; m_bad = 1;
        send_str("\n");
        n_checks++;
        if (got_val.size() != 0) begin
            n_fail++;
            $display("FAIL frame_no_word: got %0d words want 0", got_val.size());
        end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== {x_frame, x_char, x_ovf, x_ovr, x_par}) begin
            n_fail++;
            $display("FAIL frame_errs: got %b want %b", {d_frame, d_char, d_ovf, d_ovr, d_par},
                     {x_frame, x_char, x_ovf, x_ovr, x_par});
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        x_frame = 0; x_char = 0; x_ovf = 0; x_ovr = 0; x_par = 0;
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== 5'b0) begin
            n_fail++;
            $display("FAIL clr_errs: got %b want 00000", {d_frame, d_char, d_ovf, d_ovr, d_par});
        end
    endtask

    task automatic test_reset_midbyte();
        logic [7:0] b;
        clear_queues();
        b = "B";
        send_str("A");
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b[i]);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_str("C\n");
        n_checks++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            n_fail++;
            $display("FAIL rst_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            n_checks++;
            if (got_val[0] !== exp_val[0] || got_val[0] !== 32'hC || got_dig[0] != 1) begin
                n_fail++;
                $display("FAIL rst_word: got %h/%0d want 0000000c/1", got_val[0], got_dig[0]);
            end
        end
    endtask

`ifdef UART_HEX_PARITY_EN
    task automatic test_parity();
        clear_queues();
        send_byte("3", 1'b0, 1'b1);
        x_par = 1; m_bad = 1;
        send_str("\n4\n");
        n_checks++;
        if (d_par !== 1'b1) begin n_fail++; $display("FAIL parity_flag: got %b want 1", d_par); end
        n_checks++;
        if (got_val.size() != 1 || got_val[0] !== 32'h4) begin
            n_fail++;
            $display("FAIL parity_word: got %0d words want one word 4", got_val.size());
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] bads[4];
        logic [7:0] c;
        int         nz, len, r, n;
        bads = '{8'h78, 8'h20, 8'h47, 8'h2D};
        clear_queues();
        ready = 1'b1;
        for (int line = 0; line < 12; line++) begin
            nz  = $urandom_range(0, 3);
            len = $urandom_range(1, 9);
            for (int i = 0; i < nz + len; i++) begin
                r = $urandom_range(0, 39);
                n = $urandom_range(0, 15);
                if (i < nz) c = "0";
                else if (r == 0) c = bads[$urandom_range(0, 3)];
                else if (r == 1) c = 8'h0D;
                else if (n < 10) c = 8'(8'h30 + n);
                else c = 8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + n - 10);
                send_byte(c, 1'b0, 1'b0);
                model_char(c);
            end
            send_str("\n");
        end
        n_checks++;
        if (got_val.size() != exp_val.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            foreach (exp_val[i]) begin
                n_checks++;
                if (got_val[i] !== exp_val[i] || got_dig[i] != exp_dig[i]) begin
                    n_fail++;
                    $display("FAIL rand_word%0d: got %h/%0d want %h/%0d",
                             i, got_val[i], got_dig[i], exp_val[i], exp_dig[i]);
                end
            end
        end
        n_checks++;
        if ({d_frame, d_char, d_ovf, d_ovr, d_par} !== {x_frame, x_char, x_ovf, x_ovr, x_par}) begin
            n_fail++;
            $display("FAIL rand_errs: got %b want %b", {d_frame, d_char, d_ovf, d_ovr, d_par},
                     {x_frame, x_char, x_ovf, x_ovr, x_par});
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_ovf();
        test_char_err();
        test_overrun();
        test_frame_err_clr();
        test_reset_midbyte();
`ifdef UART_HEX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
